// File: rtl/kore_regfile_rsp.sv
// Register-file responder for the kore functional FSM: operand reads, result
// write-back with bypass, and per-operation protocol tracking with a sticky error flag.
module kore_regfile_rsp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_rd,
  input  logic [ADDR_W-1:0] reg_sel,
  output logic [DATA_W-1:0] data_bus,
  output logic              rd_vld,
  input  logic              reg_wt,
  input  logic [ADDR_W-1:0] wt_addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              dout_rdy,
  output logic              wt_ack,
  input  logic              eop,
  output logic              busy,
  output logic              err,
  output logic [2:0]        rd_cnt
);

  typedef enum logic [1:0] {IDLE, ACTIVE, WRITTEN} state_t;

  localparam logic [ADDR_W:0] NREG_L = (ADDR_W+1)'(NREG);

  state_t            state, state_n;
  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] rd_data;
  logic              wr_acc, rd_oob, wt_oob, err_ev;
  logic [2:0]        cnt_n;

  assign wr_acc = reg_wt & dout_rdy;
  assign rd_oob = {1'b0, reg_sel} >= NREG_L;
  assign wt_oob = {1'b0, wt_addr} >= NREG_L;
  assign busy   = (state != IDLE);

  // Write-first bypass: a same-edge write to the read index wins over the array.
  always_comb begin
    rd_data = '0;
    if (!rd_oob && reg_sel != '0) begin
      if (wr_acc && wt_addr == reg_sel) rd_data = data_in;
      else                              rd_data = regs[reg_sel];
    end
  end

  // Events at one edge are applied in order: read, then write, then eop.
  always_comb begin
    state_n = state;
    err_ev  = 1'b0;
    if (reg_rd) begin
      if (rd_oob) err_ev = 1'b1;
      if (state == WRITTEN)   err_ev  = 1'b1;
      else if (state == IDLE) state_n = ACTIVE;
    end
    if (wr_acc) begin
      if (wt_oob || state_n == WRITTEN) err_ev = 1'b1;
      state_n = WRITTEN;
    end
    if (eop) begin
      if (state_n != WRITTEN) err_ev = 1'b1;
      state_n = IDLE;
    end
  end

  always_comb begin
    cnt_n = rd_cnt;
    if (eop)                          cnt_n = '0;
    else if (reg_rd && rd_cnt != 3'd7) cnt_n = rd_cnt + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_acc && !wt_oob && wt_addr != '0) begin
      regs[wt_addr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      data_bus <= '0;
      rd_vld   <= 1'b0;
      wt_ack   <= 1'b0;
      err      <= 1'b0;
      rd_cnt   <= '0;
    end else begin
      state  <= state_n;
      rd_vld <= reg_rd;
      wt_ack <= wr_acc;
      rd_cnt <= cnt_n;
      if (reg_rd) data_bus <= rd_data;
      if (err_ev) err      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_kore_regfile_rsp.sv
// Scoreboard bench for kore_regfile_rsp: directed plan items plus random traffic
// checked against a flag-based operation model.
module tb_kore_regfile_rsp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 24;

  logic          clk = 1'b0;
  logic          rst, reg_rd, reg_wt, dout_rdy, eop;
  logic [AW-1:0] reg_sel, wt_addr;
  logic [DW-1:0] data_in, data_bus;
  logic          rd_vld, wt_ack, busy, err;
  logic [2:0]    rd_cnt;

  kore_regfile_rsp #(.DATA_W(DW), .ADDR_W(AW), .NREG(NR)) dut (
    .clk(clk), .rst(rst), .reg_rd(reg_rd), .reg_sel(reg_sel), .data_bus(data_bus),
    .rd_vld(rd_vld), .reg_wt(reg_wt), .wt_addr(wt_addr), .data_in(data_in),
    .dout_rdy(dout_rdy), .wt_ack(wt_ack), .eop(eop), .busy(busy), .err(err),
    .rd_cnt(rd_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          vld;
    logic [DW-1:0] data;
    logic          ack, bsy, er;
    logic [2:0]    cnt;
  } exp_t;

  exp_t          sq[$];
  logic [DW-1:0] dq[$];
  int            checks = 0, errors = 0;

  // Reference model: register contents plus two flags describing the operation.
  logic [DW-1:0] m_reg [NR];
  bit            m_read_seen, m_wrote, m_err;
  int            m_cnt;
  logic [DW-1:0] m_data;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit rd, input int sel, input bit wt,
                      input int addr, input logic [DW-1:0] din, input bit rdy, input bit ep);
    exp_t e;
    bit   acc;
    rst = r; reg_rd = rd; reg_sel = AW'(sel); reg_wt = wt; wt_addr = AW'(addr);
    data_in = din; dout_rdy = rdy; eop = ep;
    acc = wt && rdy;
    e.vld = 1'b0; e.ack = 1'b0;
    if (r) begin
      for (int i = 0; i < NR; i++) m_reg[i] = '0;
      m_read_seen = 0; m_wrote = 0; m_err = 0; m_cnt = 0; m_data = '0;
    end else begin
      if (rd) begin
        if (sel == 0 || sel >= NR) m_data = '0;
        else if (acc && addr == sel) m_data = din;
        else m_data = m_reg[sel];
        dq.push_back(m_data);
        e.vld = 1'b1;
        if (sel >= NR || m_wrote) m_err = 1;
        if (!m_wrote) m_read_seen = 1;
        if (m_cnt < 7) m_cnt++;
      end
      if (acc) begin
        if (m_wrote || addr >= NR) m_err = 1;
        if (addr != 0 && addr < NR) m_reg[addr] = din;
        m_wrote = 1;
        e.ack = 1'b1;
      end
      if (ep) begin
        if (!m_wrote) m_err = 1;
        m_read_seen = 0; m_wrote = 0; m_cnt = 0;
      end
    end
    e.data = m_data;
    e.bsy  = m_read_seen || m_wrote;
    e.er   = m_err;
    e.cnt  = 3'(m_cnt);
    sq.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, '0, 0, 0);
  endtask

  // Monitor: one status expectation per cycle; read data popped on each rd_vld.
  initial begin
    exp_t e;
    logic [DW-1:0] d;
    forever begin
      @(negedge clk);
      if (sq.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_empty: no expectation queued at %0t", $time);
      end else begin
        e = sq.pop_front();
        chk("rd_vld", DW'(rd_vld), DW'(e.vld));
        chk("data_bus", data_bus, e.data);
        chk("wt_ack", DW'(wt_ack), DW'(e.ack));
        chk("busy", DW'(busy), DW'(e.bsy));
        chk("err", DW'(err), DW'(e.er));
        chk("rd_cnt", DW'(rd_cnt), DW'(e.cnt));
        if (rd_vld) begin
          if (dq.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_data: unexpected rd_vld at %0t", $time);
          end else begin
            d = dq.pop_front();
            chk("rd_data", data_bus, d);
          end
        end
      end
    end
  end

  initial begin
    step(1, 0, 0, 0, 0, '0, 0, 0);
    step(1, 0, 0, 0, 0, '0, 0, 0);
    step(0, 1, 5, 0, 0, '0, 0, 0);                  // read r5 after reset
    idle(1);
    step(0, 0, 0, 1, 3, 32'hDEADBEEF, 1, 0);         // write r3
    step(0, 0, 0, 0, 0, '0, 0, 1);                  // clean eop
    step(0, 1, 3, 0, 0, '0, 0, 0);
    step(0, 0, 0, 0, 0, '0, 0, 1);                  // eop while ACTIVE -> err
    step(1, 0, 0, 0, 0, '0, 0, 0);
    step(0, 1, 1, 0, 0, '0, 0, 0);                  // full op, delayed dout_rdy
    step(0, 1, 2, 0, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 4, 32'hCAFE0004, 0, 0);
    step(0, 0, 0, 1, 4, 32'hCAFE0004, 1, 0);
    step(0, 0, 0, 0, 0, '0, 0, 1);
    step(0, 1, 7, 1, 7, 32'h12345678, 1, 0);         // bypass
    step(0, 0, 0, 0, 0, '0, 0, 1);
    step(0, 0, 0, 1, 0, 32'h0000FFFF, 1, 0);         // write r0 discarded
    step(0, 1, 0, 0, 0, '0, 0, 1);
    step(0, 1, 30, 0, 0, '0, 0, 0);                 // out-of-range read
    step(0, 0, 0, 1, 9, 32'h99, 1, 0);
    step(0, 0, 0, 1, 9, 32'hAA, 1, 0);               // second write in WRITTEN
    step(0, 1, 9, 0, 0, '0, 0, 1);
    for (int i = 0; i < 9; i++) step(0, 1, i, 0, 0, '0, 0, 0);  // rd_cnt saturation
    step(0, 0, 0, 1, 6, 32'h66, 1, 0);
    step(1, 0, 0, 1, 6, 32'h77, 1, 0);               // reset with write same edge
    step(0, 1, 6, 0, 0, '0, 0, 0);
    step(0, 1, 3, 0, 0, '0, 0, 0);
    for (int i = 0; i < 3000; i++)
      step(($urandom % 97) == 0, ($urandom % 2) == 0, int'($urandom % 32),
           ($urandom % 3) == 0, int'($urandom % 32), $urandom,
           ($urandom % 3) != 0, ($urandom % 6) == 0);
    idle(1);
    @(negedge clk); #1;
    checks++;
    if (sq.size() != 0 || dq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d status and %0d data expectations left", sq.size(), dq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
